// File: rtl/regfile_seq_pkg.sv
// Shared opcode, state and width definitions for the register-file command sequencer.
package regfile_seq_pkg;

    localparam int OP_W  = 3;
    localparam int SEL_W = 3;
    localparam int CNT_W = 8;

    typedef enum logic [OP_W-1:0] {
        OP_NOP    = 3'b000,
        OP_CPYIN  = 3'b001,
        OP_CPYOUT = 3'b010,
        OP_ALU    = 3'b011,
        OP_LOAD   = 3'b100,
        OP_MOVE   = 3'b101
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_EXEC    = 3'd1,
        ST_MOVE2   = 3'd2,
        ST_MEMWAIT = 3'd3,
        ST_MEMLOAD = 3'd4
    } state_e;

endpackage

// File: rtl/regfile_seq_if.sv
// Command, memory-handshake and register-file strobe bundle of the sequencer.
interface regfile_seq_if;
    import regfile_seq_pkg::*;

    logic             cmd_valid;
    logic             cmd_ready;
    logic [OP_W-1:0]  cmd_op;
    logic [SEL_W-1:0] cmd_ra;
    logic [SEL_W-1:0] cmd_rb;
    logic             mem_req;
    logic             mem_ack;
    logic             rf_cpyin;
    logic             rf_cpyout;
    logic             rf_memload;
    logic             rf_comp;
    logic [SEL_W-1:0] rf_reg_sel;
    logic             busy;
    logic             done;
    logic             err;

    modport master (
        output cmd_valid, cmd_op, cmd_ra, cmd_rb, mem_ack,
        input  cmd_ready, mem_req, rf_cpyin, rf_cpyout, rf_memload, rf_comp,
        input  rf_reg_sel, busy, done, err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_ra, cmd_rb, mem_ack,
        output cmd_ready, mem_req, rf_cpyin, rf_cpyout, rf_memload, rf_comp,
        output rf_reg_sel, busy, done, err
    );

endinterface

// File: rtl/regfile_seq.sv
// Register-file command sequencer: decodes one command at a time into register-file
// strobes, with a bounded wait on data memory for LOAD. All outputs are registered.
//
//   state      | meaning
//   IDLE       | cmd_ready high, waiting for a command
//   EXEC       | single-cycle op / MOVE first half / illegal or LOAD timeout completion
//   MOVE2      | MOVE second half: copy res into rb
//   MEMWAIT    | mem_req held, counting cycles until mem_ack or timeout
//   MEMLOAD    | write memory data into ra
module regfile_seq
    import regfile_seq_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic         clk,
    input  logic         rst_n,
    regfile_seq_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    state_e           state_q;
    logic [OP_W-1:0]  op_q;
    logic [SEL_W-1:0] ra_q;
    logic [SEL_W-1:0] rb_q;
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            op_q           <= OP_NOP;
            ra_q           <= '0;
            rb_q           <= '0;
            cnt_q          <= '0;
            bus.cmd_ready  <= 1'b1;
            bus.mem_req    <= 1'b0;
            bus.rf_cpyin   <= 1'b0;
            bus.rf_cpyout  <= 1'b0;
            bus.rf_memload <= 1'b0;
            bus.rf_comp    <= 1'b0;
            bus.rf_reg_sel <= '0;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
            bus.err        <= 1'b0;
        end else begin
            bus.rf_cpyin   <= 1'b0;
            bus.rf_cpyout  <= 1'b0;
            bus.rf_memload <= 1'b0;
            bus.rf_comp    <= 1'b0;
            bus.done       <= 1'b0;
            bus.err        <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (bus.cmd_valid && bus.cmd_ready) begin
                        op_q          <= bus.cmd_op;
                        ra_q          <= bus.cmd_ra;
                        rb_q          <= bus.cmd_rb;
                        cnt_q         <= '0;
                        bus.cmd_ready <= 1'b0;
                        bus.busy      <= 1'b1;
                        state_q       <= ST_EXEC;
                        case (bus.cmd_op)
                            OP_NOP: begin
                                bus.done <= 1'b1;
                            end
                            OP_CPYIN: begin
                                bus.rf_cpyin   <= 1'b1;
                                bus.rf_reg_sel <= bus.cmd_ra;
                                bus.done       <= 1'b1;
                            end
                            OP_CPYOUT: begin
                                bus.rf_cpyout  <= 1'b1;
                                bus.rf_reg_sel <= bus.cmd_ra;
                                bus.done       <= 1'b1;
                            end
                            OP_ALU: begin
                                bus.rf_comp    <= 1'b1;
                                bus.rf_reg_sel <= bus.cmd_ra;
                                bus.done       <= 1'b1;
                            end
                            OP_MOVE: begin
                                bus.rf_cpyin   <= 1'b1;
                                bus.rf_reg_sel <= bus.cmd_ra;
                            end
                            OP_LOAD: begin
                                bus.mem_req <= 1'b1;
                                state_q     <= ST_MEMWAIT;
                            end
                            default: begin
                                bus.done <= 1'b1;
                                bus.err  <= 1'b1;
                            end
                        endcase
                    end
                end

                ST_EXEC: begin
                    if (op_q == OP_MOVE) begin
                        bus.rf_cpyout  <= 1'b1;
                        bus.rf_reg_sel <= rb_q;
                        bus.done       <= 1'b1;
                        state_q        <= ST_MOVE2;
                    end else begin
                        bus.cmd_ready <= 1'b1;
                        bus.busy      <= 1'b0;
                        state_q       <= ST_IDLE;
                    end
                end

                ST_MEMWAIT: begin
                    // An ack on the last allowed cycle is checked before the timeout.
                    if (bus.mem_ack) begin
                        bus.mem_req    <= 1'b0;
                        bus.rf_memload <= 1'b1;
                        bus.rf_reg_sel <= ra_q;
                        bus.done       <= 1'b1;
                        state_q        <= ST_MEMLOAD;
                    end else if (cnt_q == CNT_LAST) begin
                        bus.mem_req <= 1'b0;
                        bus.done    <= 1'b1;
                        bus.err     <= 1'b1;
                        state_q     <= ST_EXEC;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                ST_MOVE2, ST_MEMLOAD: begin
                    bus.cmd_ready <= 1'b1;
                    bus.busy      <= 1'b0;
                    state_q       <= ST_IDLE;
                end

                default: begin
                    bus.cmd_ready <= 1'b1;
                    bus.busy      <= 1'b0;
                    bus.mem_req   <= 1'b0;
                    state_q       <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
